// File: rtl/interrupt_ack_sequencer.sv
// Clocked INTA/poll acknowledge sequencer for the 8259A control-logic path.
// Optional macro ACK_SEQ_AUTO_EOI_EN adds the auto-EOI ISR clear output.
module interrupt_ack_sequencer #(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               write_initial_command_word_1,
    input  logic               u8086_or_mcs80_config,
    input  logic               poll_command,
    input  logic               interrupt_acknowledge_n,
    input  logic               read,
    input  logic [NUM_IRQ-1:0] interrupt,
    output logic [2:0]         control_state,
    output logic               interrupt_to_cpu,
    output logic               freeze,
    output logic               latch_in_service,
    output logic [NUM_IRQ-1:0] clear_interrupt_request,
    output logic [NUM_IRQ-1:0] acknowledge_interrupt,
    output logic [NUM_IRQ-1:0] interrupt_when_ack1,
    output logic               end_of_acknowledge_sequence,
    output logic               end_of_poll_command
`ifdef ACK_SEQ_AUTO_EOI_EN
    ,
    input  logic               auto_eoi_config,
    output logic [NUM_IRQ-1:0] auto_eoi_clear
`endif
);

    typedef enum logic [2:0] {
        READY = 3'd0,
        ACK1  = 3'd1,
        ACK2  = 3'd2,
        ACK3  = 3'd3,
        POLL  = 3'd4
    } state_t;

    state_t state;
    logic   inta_prev;
    logic   read_prev;
    logic   inta_fall;
    logic   inta_rise;
    logic   read_rise;
    logic   read_fall;
    logic   end_pulse;

    assign inta_fall = inta_prev & ~interrupt_acknowledge_n;
    assign inta_rise = ~inta_prev & interrupt_acknowledge_n;
    assign read_rise = ~read_prev & read;
    assign read_fall = read_prev & ~read;
    assign end_pulse = end_of_acknowledge_sequence | end_of_poll_command;

    assign control_state = state;
    assign freeze        = (state != READY);

    // IRR clear: everything on ICW1, otherwise only the winner being latched
    always_comb begin
        clear_interrupt_request = '0;
        if (write_initial_command_word_1) begin
            clear_interrupt_request = '1;
        end else if (latch_in_service) begin
            clear_interrupt_request = interrupt;
        end
    end

`ifdef ACK_SEQ_AUTO_EOI_EN
    always_comb begin
        auto_eoi_clear = '0;
        if (auto_eoi_config && end_of_acknowledge_sequence) begin
            auto_eoi_clear = acknowledge_interrupt;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state                       <= READY;
            inta_prev                   <= 1'b1;
            read_prev                   <= 1'b0;
            interrupt_to_cpu            <= 1'b0;
            latch_in_service            <= 1'b0;
            acknowledge_interrupt       <= '0;
            interrupt_when_ack1         <= '0;
            end_of_acknowledge_sequence <= 1'b0;
            end_of_poll_command         <= 1'b0;
        end else begin
            inta_prev                   <= interrupt_acknowledge_n;
            read_prev                   <= read;
            latch_in_service            <= 1'b0;
            end_of_acknowledge_sequence <= 1'b0;
            end_of_poll_command         <= 1'b0;

            if (write_initial_command_word_1) begin
                state                 <= READY;
                interrupt_to_cpu      <= 1'b0;
                acknowledge_interrupt <= '0;
                interrupt_when_ack1   <= '0;
            end else begin
                case (state)
                    READY: begin
                        if (poll_command) begin
                            state <= POLL;
                        end else if (inta_fall) begin
                            state            <= ACK1;
                            latch_in_service <= 1'b1;
                        end
                    end
                    ACK1: begin
                        if (inta_fall) begin
                            state <= ACK2;
                        end
                    end
                    ACK2: begin
                        if (u8086_or_mcs80_config) begin
                            if (inta_rise) begin
                                state                       <= READY;
                                end_of_acknowledge_sequence <= 1'b1;
                            end
                        end else if (inta_fall) begin
                            state <= ACK3;
                        end
                    end
                    ACK3: begin
                        // Unreachable in 8086 mode; bail out silently if entered
                        if (u8086_or_mcs80_config) begin
                            state <= READY;
                        end else if (inta_rise) begin
                            state                       <= READY;
                            end_of_acknowledge_sequence <= 1'b1;
                        end
                    end
                    POLL: begin
                        if (read_fall) begin
                            state               <= READY;
                            end_of_poll_command <= 1'b1;
                        end else if (read_rise) begin
                            latch_in_service <= 1'b1;
                        end else if (!poll_command && !read) begin
                            state <= READY;
                        end
                    end
                    default: state <= READY;
                endcase

                // Clear beats set; a persisting request re-asserts next cycle
                if (end_pulse) begin
                    interrupt_to_cpu <= 1'b0;
                end else if (|interrupt) begin
                    interrupt_to_cpu <= 1'b1;
                end

                if (latch_in_service) begin
                    acknowledge_interrupt <= interrupt;
                end else if (end_pulse) begin
                    acknowledge_interrupt <= '0;
                end

                if (state == ACK1) begin
                    interrupt_when_ack1 <= interrupt;
                end
            end
        end
    end

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed self-checking bench for interrupt_ack_sequencer (8- and 16-line instances).
// Build with ACK_SEQ_AUTO_EOI_EN defined to also exercise the auto-EOI clear.
module tb_interrupt_ack_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        icw1;
    logic        mode_8086;
    logic        poll;
    logic        inta_n;
    logic        rd;
    logic [7:0]  irq;
    logic [15:0] irq16;

    logic [2:0]  state;
    logic        int_cpu;
    logic        frz;
    logic        latch;
    logic [7:0]  clr;
    logic [7:0]  ack;
    logic [7:0]  ack1;
    logic        eoa;
    logic        eop;

    logic [2:0]  state16;
    logic        int_cpu16;
    logic        frz16;
    logic        latch16;
    logic [15:0] clr16;
    logic [15:0] ack16;
    logic [15:0] ack1_16;
    logic        eoa16;
    logic        eop16;

`ifdef ACK_SEQ_AUTO_EOI_EN
    logic        auto_cfg;
    logic [7:0]  aeoi;
    logic [15:0] aeoi16;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    interrupt_ack_sequencer #(.NUM_IRQ(8)) u_dut (
        .clock                        (clock),
        .reset                        (reset),
        .write_initial_command_word_1 (icw1),
        .u8086_or_mcs80_config        (mode_8086),
        .poll_command                 (poll),
        .interrupt_acknowledge_n      (inta_n),
        .read                         (rd),
        .interrupt                    (irq),
        .control_state                (state),
        .interrupt_to_cpu             (int_cpu),
        .freeze                       (frz),
        .latch_in_service             (latch),
        .clear_interrupt_request      (clr),
        .acknowledge_interrupt        (ack),
        .interrupt_when_ack1          (ack1),
        .end_of_acknowledge_sequence  (eoa),
        .end_of_poll_command          (eop)
`ifdef ACK_SEQ_AUTO_EOI_EN
        ,
        .auto_eoi_config              (auto_cfg),
        .auto_eoi_clear               (aeoi)
`endif
    );

    interrupt_ack_sequencer #(.NUM_IRQ(16)) u_dut16 (
        .clock                        (clock),
        .reset                        (reset),
        .write_initial_command_word_1 (icw1),
        .u8086_or_mcs80_config        (mode_8086),
        .poll_command                 (poll),
        .interrupt_acknowledge_n      (inta_n),
        .read                         (rd),
        .interrupt                    (irq16),
        .control_state                (state16),
        .interrupt_to_cpu             (int_cpu16),
        .freeze                       (frz16),
        .latch_in_service             (latch16),
        .clear_interrupt_request      (clr16),
        .acknowledge_interrupt        (ack16),
        .interrupt_when_ack1          (ack1_16),
        .end_of_acknowledge_sequence  (eoa16),
        .end_of_poll_command          (eop16)
`ifdef ACK_SEQ_AUTO_EOI_EN
        ,
        .auto_eoi_config              (auto_cfg),
        .auto_eoi_clear               (aeoi16)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and sample shortly after it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; icw1 = 1'b0; mode_8086 = 1'b1; poll = 1'b0;
        inta_n = 1'b1; rd = 1'b0; irq = 8'h00; irq16 = 16'h0000;
`ifdef ACK_SEQ_AUTO_EOI_EN
        auto_cfg = 1'b0;
`endif
        tick(); tick();
        chk("rst_state",  32'(state),   32'd0);
        chk("rst_int",    32'(int_cpu), 32'd0);
        chk("rst_freeze", 32'(frz),     32'd0);
        chk("rst_latch",  32'(latch),   32'd0);
        chk("rst_ack",    32'(ack),     32'd0);
        chk("rst_ack1",   32'(ack1),    32'd0);
        chk("rst_eoa",    32'(eoa),     32'd0);
        chk("rst_eop",    32'(eop),     32'd0);
        chk("rst_clr",    32'(clr),     32'd0);
        reset = 1'b0;

        // 8086 mode, IR2
        irq = 8'h04; tick();
        chk("t1_int_set", 32'(int_cpu), 32'd1);
        inta_n = 1'b0; tick();
        chk("t1_ack1",    32'(state), 32'd1);
        chk("t1_latch",   32'(latch), 32'd1);
        chk("t1_clr",     32'(clr),   32'h04);
        chk("t1_freeze",  32'(frz),   32'd1);
        tick();
        chk("t1_latch_w", 32'(latch), 32'd0);
        chk("t1_ackirq",  32'(ack),   32'h04);
        chk("t1_wack1",   32'(ack1),  32'h04);
        inta_n = 1'b1; tick();
        chk("t1_hold1",   32'(state), 32'd1);
        inta_n = 1'b0; tick();
        chk("t1_ack2",    32'(state), 32'd2);
        inta_n = 1'b1; irq = 8'h00; tick();
        chk("t1_ready",   32'(state),   32'd0);
        chk("t1_eoa",     32'(eoa),     32'd1);
        chk("t1_int_hd",  32'(int_cpu), 32'd1);
        tick();
        chk("t1_eoa_w",   32'(eoa),     32'd0);
        chk("t1_int_clr", 32'(int_cpu), 32'd0);
        chk("t1_ack_clr", 32'(ack),     32'd0);

        // MCS-80 mode, IR7, three pulses
        mode_8086 = 1'b0; irq = 8'h80; tick();
        chk("t2_int_set", 32'(int_cpu), 32'd1);
        inta_n = 1'b0; tick();
        chk("t2_ack1",    32'(state), 32'd1);
        inta_n = 1'b1; tick();
        chk("t2_ackirq",  32'(ack),   32'h80);
        inta_n = 1'b0; tick();
        chk("t2_ack2",    32'(state), 32'd2);
        inta_n = 1'b1; tick();
        chk("t2_ack2_hd", 32'(state), 32'd2);
        chk("t2_no_eoa",  32'(eoa),   32'd0);
        chk("t2_freeze",  32'(frz),   32'd1);
        inta_n = 1'b0; tick();
        chk("t2_ack3",    32'(state), 32'd3);
        chk("t2_frz3",    32'(frz),   32'd1);
        inta_n = 1'b1; irq = 8'h00; tick();
        chk("t2_ready",   32'(state), 32'd0);
        chk("t2_eoa",     32'(eoa),   32'd1);
        tick();
        chk("t2_eoa_w",   32'(eoa),     32'd0);
        chk("t2_ack_clr", 32'(ack),     32'd0);
        chk("t2_int_clr", 32'(int_cpu), 32'd0);

        // Poll, IR4
        mode_8086 = 1'b1; poll = 1'b1; irq = 8'h10; tick();
        chk("t3_poll",    32'(state),   32'd4);
        chk("t3_freeze",  32'(frz),     32'd1);
        chk("t3_int",     32'(int_cpu), 32'd1);
        rd = 1'b1; tick();
        chk("t3_latch",   32'(latch), 32'd1);
        chk("t3_clr",     32'(clr),   32'h10);
        tick();
        chk("t3_latch_w", 32'(latch), 32'd0);
        chk("t3_ackirq",  32'(ack),   32'h10);
        rd = 1'b0; poll = 1'b0; irq = 8'h00; tick();
        chk("t3_ready",   32'(state), 32'd0);
        chk("t3_eop",     32'(eop),   32'd1);
        tick();
        chk("t3_eop_w",   32'(eop),     32'd0);
        chk("t3_ack_clr", 32'(ack),     32'd0);
        chk("t3_int_clr", 32'(int_cpu), 32'd0);

        // Poll dropped without a read
        poll = 1'b1; tick();
        chk("t3b_poll",   32'(state), 32'd4);
        poll = 1'b0; tick();
        chk("t3b_ready",  32'(state), 32'd0);
        chk("t3b_no_eop", 32'(eop),   32'd0);

        // ICW1 during ACK2
        mode_8086 = 1'b0; irq = 8'h02; tick();
        chk("t4_int", 32'(int_cpu), 32'd1);
        inta_n = 1'b0; tick();
        inta_n = 1'b1; tick();
        chk("t4_ackirq", 32'(ack), 32'h02);
        inta_n = 1'b0; tick();
        chk("t4_ack2",   32'(state), 32'd2);
        chk("t4_wack1",  32'(ack1),  32'h02);
        icw1 = 1'b1; #1;
        chk("t4_clr_all", 32'(clr), 32'hFF);
        tick();
        chk("t4_ready",  32'(state),   32'd0);
        chk("t4_int0",   32'(int_cpu), 32'd0);
        chk("t4_ack0",   32'(ack),     32'd0);
        chk("t4_wack0",  32'(ack1),    32'd0);
        chk("t4_no_eoa", 32'(eoa),     32'd0);
        icw1 = 1'b0; irq = 8'h00; inta_n = 1'b1; tick();
        chk("t4_idle",   32'(state), 32'd0);
        chk("t4_eoa_nr", 32'(eoa),   32'd0);

        // 16 lines: IR15 held across the end pulse; 8-line instance sees a spurious INTA
        mode_8086 = 1'b1; irq16 = 16'h8000; tick();
        chk("t5_int16", 32'(int_cpu16), 32'd1);
        inta_n = 1'b0; tick();
        chk("t5_latch", 32'(latch), 32'd1);
        inta_n = 1'b1; tick();
        chk("t5_spur_ack", 32'(ack),   32'd0);
        chk("t5_ack16",    32'(ack16), 32'h8000);
        inta_n = 1'b0; tick();
        chk("t5_ack2_16",  32'(state16), 32'd2);
        inta_n = 1'b1; tick();
        chk("t5_eoa16",    32'(eoa16),     32'd1);
        chk("t5_int16_hd", 32'(int_cpu16), 32'd1);
        tick();
        chk("t5_int16_lo", 32'(int_cpu16), 32'd0);
        tick();
        chk("t5_int16_hi", 32'(int_cpu16), 32'd1);
        irq16 = 16'h0000;

        // Reset mid-sequence, then a fresh sequence
        inta_n = 1'b0; tick();
        chk("t6_ack1", 32'(state), 32'd1);
        reset = 1'b1; inta_n = 1'b1; tick();
        chk("t6_rst_state",  32'(state), 32'd0);
        chk("t6_rst_freeze", 32'(frz),   32'd0);
        reset = 1'b0; irq = 8'h01; inta_n = 1'b0; tick();
        chk("t6_fresh", 32'(state), 32'd1);
        chk("t6_latch", 32'(latch), 32'd1);
        inta_n = 1'b1; tick();
        chk("t6_ackirq", 32'(ack), 32'h01);
        inta_n = 1'b0; tick();
        inta_n = 1'b1; irq = 8'h00; tick();
        chk("t6_eoa", 32'(eoa), 32'd1);
        tick();

        // ACK3 reached, then mode flips to 8086: silent return to READY
        mode_8086 = 1'b0;
        inta_n = 1'b0; tick();
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        chk("t7_ack3", 32'(state), 32'd3);
        mode_8086 = 1'b1; tick();
        chk("t7_ready",  32'(state), 32'd0);
        chk("t7_no_eoa", 32'(eoa),   32'd0);
        inta_n = 1'b1; tick();
        chk("t7_no_eoa2", 32'(eoa), 32'd0);

`ifdef ACK_SEQ_AUTO_EOI_EN
        // Auto EOI on IR3
        auto_cfg = 1'b1; irq = 8'h08; tick();
        inta_n = 1'b0; tick();
        inta_n = 1'b1; tick();
        chk("t8_ackirq", 32'(ack), 32'h08);
        chk("t8_aeoi_idle", 32'(aeoi), 32'd0);
        inta_n = 1'b0; tick();
        inta_n = 1'b1; irq = 8'h00; tick();
        chk("t8_eoa",  32'(eoa),  32'd1);
        chk("t8_aeoi", 32'(aeoi), 32'h08);
        tick();
        chk("t8_aeoi_w", 32'(aeoi), 32'd0);
        auto_cfg = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
